// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable, maskable PAT_W-bit pattern,
// optional overlapping matches and a saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W     = 12,
    parameter logic [PAT_W-1:0] RESET_PAT = 12'b1110_1101_1011,
    parameter bit               OVERLAP   = 1'b1,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pat_load_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [PAT_W-1:0] mask_i,
    input  logic             valid_i,
    input  logic             x_i,
    input  logic             cnt_clr_i,
    output logic             det_o,
    output logic [CNT_W-1:0] det_cnt_o
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_shift;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  mask_q;
    logic [FILL_W-1:0] fill;
    logic              accept;
    logic              full;
    logic              hit;
    logic              cnt_sat;

    // Newest bit enters at the top, so hist_shift[PAT_W-1] lines up with pat_q[PAT_W-1]
    // and the oldest bit of a full window lines up with pat_q[0].
    always_comb begin
        accept     = valid_i && !pat_load_i;
        hist_shift = {x_i, hist[PAT_W-1:1]};
        full       = (fill >= FILL_LAST);
        hit        = accept && full && (((hist_shift ^ pat_q) & mask_q) == '0);
        cnt_sat    = &det_cnt_o;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist      <= '0;
            fill      <= '0;
            pat_q     <= RESET_PAT;
            mask_q    <= '1;
            det_o     <= 1'b0;
            det_cnt_o <= '0;
        end else begin
            det_o <= hit;

            if (pat_load_i) begin
                pat_q  <= pat_i;
                mask_q <= mask_i;
                fill   <= '0;
            end else if (valid_i) begin
                hist <= hist_shift;
                if (hit && !OVERLAP) begin
                    fill <= '0;
                end else if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end

            // Clear takes effect first, so a coincident match leaves the count at one.
            if (cnt_clr_i) begin
                det_cnt_o <= hit ? CNT_W'(1) : '0;
            end else if (hit && !cnt_sat) begin
                det_cnt_o <= det_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a 12-bit overlapping instance plus two 4-bit
// instances (overlapping with 2-bit counter, non-overlapping) driven in parallel.
module tb_seq_detect_param;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_ld, a_v, a_x, a_clr;
    logic [11:0] a_pat, a_mask;
    logic        a_det;
    logic [7:0]  a_cnt;

    logic        ld, v, x, clr;
    logic [3:0]  pat, mask;
    logic        b_det, c_det;
    logic [1:0]  b_cnt;
    logic [7:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_param dut_a (
        .clk(clk), .reset_n(rst_n), .pat_load_i(a_ld), .pat_i(a_pat), .mask_i(a_mask),
        .valid_i(a_v), .x_i(a_x), .cnt_clr_i(a_clr), .det_o(a_det), .det_cnt_o(a_cnt)
    );

    seq_detect_param #(.PAT_W(4), .RESET_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(rst_n), .pat_load_i(ld), .pat_i(pat), .mask_i(mask),
        .valid_i(v), .x_i(x), .cnt_clr_i(clr), .det_o(b_det), .det_cnt_o(b_cnt)
    );

    seq_detect_param #(.PAT_W(4), .RESET_PAT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_c (
        .clk(clk), .reset_n(rst_n), .pat_load_i(ld), .pat_i(pat), .mask_i(mask),
        .valid_i(v), .x_i(x), .cnt_clr_i(clr), .det_o(c_det), .det_cnt_o(c_cnt)
    );

    typedef struct {
        logic       ld;
        logic       v;
        logic       x;
        logic       clr;
        logic [3:0] pat;
        logic [3:0] mask;
        logic       eb_det;
        int         eb_cnt;
        logic       ec_det;
        int         ec_cnt;
    } vec_t;

    typedef struct {
        int    dut;
        logic  det;
        int    cnt;
        string tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add(input logic l, input logic vv, input logic xx, input logic cc,
                                input logic [3:0] p, input logic [3:0] m,
                                input logic bd, input int bc, input logic cd, input int ccn);
        vec_t r;
        r.ld = l; r.v = vv; r.x = xx; r.clr = cc; r.pat = p; r.mask = m;
        r.eb_det = bd; r.eb_cnt = bc; r.ec_det = cd; r.ec_cnt = ccn;
        vecs.push_back(r);
    endfunction

    function automatic void push_exp(input int dut, input logic det, input int cnt, input string tag);
        exp_t e;
        e.dut = dut; e.det = det; e.cnt = cnt; e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void build_table();
        logic xb, mb, mc, cl;
        int   bcnt, ccnt;
        // overlap vs non-overlap, pattern 1011, stream 1,1,0,1,1,0,1
        add(1, 0, 0, 1, 4'b1011, 4'hF, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1, 1, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 1, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        // masked pattern with bubbles: stream 1,r,0,r
        add(1, 0, 0, 1, 4'b0001, 4'b0101, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1'($urandom_range(1, 0)), 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1'($urandom_range(1, 0)), 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1'($urandom_range(1, 0)), 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1'($urandom_range(1, 0)), 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1'($urandom_range(1, 0)), 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1'($urandom_range(1, 0)), 0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        // same mask, compared bit 2 wrong -> no match
        add(1, 0, 0, 0, 4'b0001, 4'b0101, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        // all-zero mask: matches once the window is full
        add(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 1, 2, 1, 2);
        add(0, 1, 0, 0, 0, 0, 1, 3, 0, 2);
        add(0, 1, 1, 0, 0, 0, 1, 3, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 3, 0, 2);
        // load priority: 1,1,0 then load with a valid 1 that must be dropped
        add(1, 0, 0, 1, 4'b1011, 4'hF, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 4'b1011, 4'hF, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1, 1, 1);
        // periodic stream 1,1,0,...: b saturates at 3, clear coincides with 6th match
        add(1, 0, 0, 1, 4'b1011, 4'hF, 0, 0, 0, 0);
        bcnt = 0;
        ccnt = 0;
        for (int k = 1; k <= 19; k++) begin
            xb = ((k % 3) != 0);
            mb = (k >= 4) && ((k % 3) == 1);
            mc = (k == 4) || (k == 10) || (k == 16);
            cl = (k == 19);
            if (cl) bcnt = mb ? 1 : 0;
            else if (mb && bcnt < 3) bcnt++;
            if (cl) ccnt = mc ? 1 : 0;
            else if (mc) ccnt++;
            add(0, 1, xb, cl, 0, 0, mb, bcnt, mc, ccnt);
        end
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    task automatic check_now();
        exp_t        e;
        logic        act_det;
        logic [31:0] act_cnt;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin act_det = a_det; act_cnt = 32'(a_cnt); end
                1:       begin act_det = b_det; act_cnt = 32'(b_cnt); end
                default: begin act_det = c_det; act_cnt = 32'(c_cnt); end
            endcase
            n_checks++;
            if (act_det !== e.det || act_cnt !== 32'(e.cnt)) begin
                n_fail++;
                $display("FAIL %s dut%0d: got det=%0b cnt=%0d, want det=%0b cnt=%0d",
                         e.tag, e.dut, act_det, act_cnt, e.det, e.cnt);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [11:0] rp;
        rp = 12'b1110_1101_1011;
        rst_n = 1'b0;
        a_ld = 0; a_v = 0; a_x = 0; a_clr = 0; a_pat = '0; a_mask = '0;
        ld = 0; v = 0; x = 0; clr = 0; pat = '0; mask = '0;

        repeat (2) @(posedge clk);
        #1;
        push_exp(0, 0, 0, "reset_a");
        push_exp(1, 0, 0, "reset_b");
        push_exp(2, 0, 0, "reset_c");
        check_now();
        @(negedge clk);
        rst_n = 1'b1;

        // default pattern on the 12-bit instance
        a_v = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_x = rp[i];
            push_exp(0, (i == 11), (i == 11) ? 1 : 0, $sformatf("default_bit%0d", i));
            tick();
        end
        a_v = 1'b0;
        push_exp(0, 0, 1, "default_after");
        tick();

        build_table();
        for (int n = 0; n < vecs.size(); n++) begin
            ld = vecs[n].ld; v = vecs[n].v; x = vecs[n].x; clr = vecs[n].clr;
            pat = vecs[n].pat; mask = vecs[n].mask;
            push_exp(1, vecs[n].eb_det, vecs[n].eb_cnt, $sformatf("vec%0d", n));
            push_exp(2, vecs[n].ec_det, vecs[n].ec_cnt, $sformatf("vec%0d", n));
            tick();
        end
        ld = 0; v = 0; x = 0; clr = 0;
        push_exp(0, 0, 1, "a_idle_hold");
        check_now();

        // async reset during a partial match on the 12-bit instance
        a_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_x = rp[i];
            push_exp(0, 0, 1, $sformatf("partial_bit%0d", i));
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        push_exp(0, 0, 0, "async_rst_a");
        push_exp(1, 0, 0, "async_rst_b");
        push_exp(2, 0, 0, "async_rst_c");
        check_now();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 5; i < 12; i++) begin
            a_x = rp[i];
            push_exp(0, 0, 0, $sformatf("post_rst_tail%0d", i));
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            a_x = rp[i];
            push_exp(0, (i == 11), (i == 11) ? 1 : 0, $sformatf("post_rst_bit%0d", i));
            tick();
        end
        a_v = 1'b0;
        push_exp(0, 0, 1, "post_rst_after");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: matches a runtime-programmable, optionally masked PAT_W-bit pattern against a qualified 1-bit input stream. Selectable overlapping/non-overlapping mode and a saturating match counter. Generalises the fixed-pattern single-bit detector, and sits behind any serial front end that needs framing or sync-word detection.

## Interface

- PAT_W, 12, pattern length in bits (2..32).
- RESET_PAT, 12'b1110_1101_1011, pattern loaded at reset. Bit 0 is the first bit on the wire.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match.
- CNT_W, 8, width of the match counter.
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pat_load_i  in  1  load pat_i/mask_i; clears history.
- pat_i  in  PAT_W  new pattern, bit 0 = first wire bit.
- mask_i  in  PAT_W  1 = compare bit, 0 = don't care.
- valid_i  in  1  x_i carries a sample this cycle.
- x_i  in  1  serial data bit.
- cnt_clr_i  in  1  synchronous clear of det_cnt_o.
- det_o  out  1  one-cycle match pulse, registered.
- det_cnt_o  out  CNT_W  saturating count of matches.

## Operation

- State:
  - hist: PAT_W-bit history shift register.
  - fill: count 0..PAT_W of valid bits held in history.
  - pat_q and mask_q registers.
  - det_o and det_cnt_o registers.
- Reset values: hist=0, fill=0, pat_q=RESET_PAT, mask_q=all ones, det_o=0, det_cnt_o=0.
- Sample accepted when valid_i=1 and pat_load_i=0.
  - x_i shifts into history and fill increments, saturating at PAT_W.
- Match condition, evaluated on the accepted sample:
  - the history including the new bit is full (fill+1 >= PAT_W);
  - for every i with mask_q[i]=1, the bit received PAT_W-1-i samples before the newest equals pat_q[i] (newest bit ↔ pat_q[PAT_W-1]).
- On match:
  - det_o=1 next cycle.
  - det_cnt_o increments, holding at 2^CNT_W-1.
  - If OVERLAP=0, fill←0, so the next match needs PAT_W fresh samples.
  - If OVERLAP=1, fill stays at PAT_W.
- valid_i=0: history, fill and det_cnt_o hold; det_o=0.
- pat_load_i=1:
  - pat_q←pat_i, mask_q←mask_i; fill←0; det_o←0.
  - Any simultaneous valid sample is discarded (load wins).
- cnt_clr_i=1: det_cnt_o←0. With a simultaneous match, the counter ends at 1 (clear then count); det_o still pulses.
- mask_q all zeros: every accepted sample with fill+1>=PAT_W matches.
- Reset asserted mid-stream: all state returns to reset values immediately, independent of clk; partial history is lost.

## Timing

- Latency: det_o high in the cycle after the edge that samples the final pattern bit. Exactly one cycle per match.
- Back-to-back matches (OVERLAP=1, periodic pattern): det_o can stay high on consecutive cycles; det_cnt_o counts each one.
- Non-overlap minimum match spacing: PAT_W accepted samples.
- First match after reset or load: no earlier than the PAT_W-th accepted sample.
- Outputs are registered; there is no combinational path from inputs to outputs.
- reset_n deasserts asynchronously into the design; inputs are sampled from the first rising edge with reset_n=1.

## Test plan

- Reset/default pattern (PAT_W=12, OVERLAP=1):
  - Stimulus: hold reset_n=0 for 2 cycles, release, then send bits 1,1,0,1,1,0,1,1,0,1,1,1 in wire order (RESET_PAT bit 0 first) with valid_i=1.
  - Required: det_o=0 throughout reset and the first 11 bits; single pulse one cycle after the 12th bit; det_cnt_o=1.
- Overlap vs non-overlap (PAT_W=4, pattern 4'b1011, mask 4'hF):
  - Stimulus: wire stream 1,1,0,1,1,0,1.
  - Required with OVERLAP=1: pulses after bits 4 and 7, det_cnt_o=2.
  - Required with OVERLAP=0: one pulse after bit 4, det_cnt_o=1.
- Mask and valid gaps (PAT_W=4):
  - Stimulus: load pat_i=4'b0001, mask_i=4'b0101; stream 1,x,0,x where x is random, with valid_i=0 bubbles inserted between bits.
  - Required: exactly one det_o pulse after the 4th valid bit; no change during bubbles.
- Load priority:
  - Stimulus: three matching bits sent, then pat_load_i=1 with valid_i=1.
  - Required: that sample is discarded, fill=0, and no match occurs until 4 new bits arrive.
- Counter saturation and clear (CNT_W=2):
  - Stimulus: 5 matches, then cnt_clr_i coinciding with a 6th match.
  - Required: det_cnt_o reads 1,2,3,3,3, then 1.
- Asynchronous reset:
  - Stimulus: assert reset_n=0 mid-cycle during a partial match.
  - Required: det_o=0 and det_cnt_o=0 immediately; a full PAT_W bits are needed for the next match.
